project_switch_sequencer: RTL and testbench

//  Owns the active-project selection and pad-direction (io_oeb) configuration in the multi-project harness.

---
 rtl/harness_pkg.sv | 10 +
 rtl/seq_down_counter.sv | 22 ++
 rtl/project_switch_sequencer.sv | 137 +++++++++++++
 tb/tb_project_switch_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/harness_pkg.sv
// Shared harness definitions: pad count, project id limits and the switch
// sequencer state encoding.
package harness_pkg;
  localparam int MPRJ_IO_PADS = 38;
  localparam int MAX_PROJECTS = 256;

  typedef enum logic [1:0] {IDLE, QUIESCE, SWITCH, RELEASE} seq_state_t;

  localparam logic [MPRJ_IO_PADS-1:0] OEB_ALL_INPUT = '1;
endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module seq_down_counter #(
  parameter int           W       = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      count <= RST_VAL;
    else if (load)                count <= load_val;
    else if (dec && count != '0)  count <= count - W'(1);
  end

  assign zero = (count == '0);
endmodule

// File: rtl/project_switch_sequencer.sv
// Active-project selector: every change tri-states pads, holds both projects
// in reset around the mux switch, then applies the incoming project's oeb.
module project_switch_sequencer
  import harness_pkg::*;
#(
  parameter int NUM_PROJECTS   = 8,
  parameter int IO_PADS        = MPRJ_IO_PADS,
  parameter int QUIESCE_CYCLES = 4,
  parameter int RESET_CYCLES   = 8,
  parameter int PERIOD_W       = 32
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [7:0]              req_project,
  input  logic                    cfg_we,
  input  logic [7:0]              cfg_project,
  input  logic [IO_PADS-1:0]      cfg_oeb,
  input  logic                    rotate_en,
  input  logic [PERIOD_W-1:0]     rotate_period,
  output logic [7:0]              active_project,
  output logic [IO_PADS-1:0]      io_oeb,
  output logic [NUM_PROJECTS-1:0] proj_reset,
  output logic                    busy,
  output logic                    done,
  output logic                    err_invalid
);
  localparam int IDX_W   = (NUM_PROJECTS > 1) ? $clog2(NUM_PROJECTS) : 1;
  localparam int CNT_MAX = (QUIESCE_CYCLES > RESET_CYCLES) ? QUIESCE_CYCLES : RESET_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] Q_LOAD = CNT_W'(QUIESCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] R_LOAD = CNT_W'(RESET_CYCLES - 1);
  // Boot release starts one count higher: the first post-reset edge only
  // narrows proj_reset down to project 0, which then gets the full hold.
  localparam logic [CNT_W-1:0] R_BOOT = CNT_W'(RESET_CYCLES);
  localparam logic [7:0]       LAST_ID = 8'(NUM_PROJECTS - 1);
  localparam logic [IO_PADS-1:0] OEB_OFF = '1;

  seq_state_t                           state;
  logic [7:0]                           target;
  logic [NUM_PROJECTS-1:0][IO_PADS-1:0] oeb_table;
  logic [PERIOD_W-1:0]                  dwell;
  logic                                 rot_on, rot_fire, ext_take, ext_ok, cfg_ok, start;
  logic [7:0]                           start_id, next_id;
  logic                                 cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]                     cnt_val;

  function automatic logic [NUM_PROJECTS-1:0] onehot(input logic [IDX_W-1:0] idx);
    return NUM_PROJECTS'(1) << idx;
  endfunction

  assign rot_on   = rotate_en && (rotate_period != '0);
  assign rot_fire = (state == IDLE) && rot_on && (dwell >= rotate_period - PERIOD_W'(1));
  assign ext_take = req_valid && req_ready;
  assign ext_ok   = ext_take && ({24'd0, req_project} < 32'(NUM_PROJECTS));
  assign cfg_ok   = {24'd0, cfg_project} < 32'(NUM_PROJECTS);
  assign next_id  = (active_project >= LAST_ID) ? 8'd0 : active_project + 8'd1;
  // An external request in the expiry cycle wins, even when it is rejected.
  assign start    = ext_ok || (rot_fire && !ext_take);
  assign start_id = ext_take ? req_project : next_id;

  // One counter times both QUIESCE and RELEASE; they never overlap.
  assign cnt_load = start || (state == SWITCH);
  assign cnt_val  = (state == SWITCH) ? R_LOAD : Q_LOAD;
  assign cnt_dec  = (state == QUIESCE) || (state == RELEASE);

  seq_down_counter #(.W(CNT_W), .RST_VAL(R_BOOT)) u_cnt (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)               oeb_table <= '1;
    else if (cfg_we && cfg_ok)  oeb_table[cfg_project[IDX_W-1:0]] <= cfg_oeb;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)                                    dwell <= '0;
    else if (!rot_on || state == SWITCH || rot_fire) dwell <= '0;
    else if (state == IDLE && dwell != '1)           dwell <= dwell + PERIOD_W'(1);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state          <= RELEASE;
      target         <= '0;
      active_project <= '0;
      io_oeb         <= OEB_OFF;
      proj_reset     <= '1;
      busy           <= 1'b1;
      req_ready      <= 1'b0;
      done           <= 1'b0;
      err_invalid    <= 1'b0;
    end else begin
      done        <= 1'b0;
      err_invalid <= 1'b0;
      case (state)
        IDLE: begin
          if (ext_take && !ext_ok) begin
            err_invalid <= 1'b1;
          end else if (start) begin
            state      <= QUIESCE;
            target     <= start_id;
            io_oeb     <= OEB_OFF;
            proj_reset <= onehot(active_project[IDX_W-1:0]);
            busy       <= 1'b1;
            req_ready  <= 1'b0;
          end
        end
        QUIESCE: if (cnt_zero) state <= SWITCH;
        SWITCH: begin
          active_project <= target;
          proj_reset     <= onehot(target[IDX_W-1:0]);
          state          <= RELEASE;
        end
        RELEASE: begin
          if (cnt_zero) begin
            state      <= IDLE;
            proj_reset <= '0;
            io_oeb     <= oeb_table[target[IDX_W-1:0]];
            done       <= 1'b1;
            busy       <= 1'b0;
            req_ready  <= 1'b1;
          end else begin
            proj_reset <= onehot(target[IDX_W-1:0]);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_project_switch_sequencer.sv
// Directed bench for project_switch_sequencer with an elapsed-time reference
// model checked every cycle plus literal spot checks.
module tb_project_switch_sequencer;
  import harness_pkg::*;

  localparam int Q = 4;
  localparam int R = 8;
  localparam logic [37:0] ALL1 = OEB_ALL_INPUT;

  logic        clk = 1'b0, rst = 1'b0;
  logic        req_valid, req_ready, cfg_we, rotate_en;
  logic [7:0]  req_project, cfg_project, active_project, proj_reset;
  logic [37:0] cfg_oeb, io_oeb;
  logic [31:0] rotate_period;
  logic        busy, done, err_invalid;

  int n_cmp = 0, n_bad = 0;

  project_switch_sequencer dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_project(req_project),
    .cfg_we(cfg_we), .cfg_project(cfg_project), .cfg_oeb(cfg_oeb),
    .rotate_en(rotate_en), .rotate_period(rotate_period),
    .active_project(active_project), .io_oeb(io_oeb), .proj_reset(proj_reset),
    .busy(busy), .done(done), .err_invalid(err_invalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a sequence is described by its accept cycle t0; every output follows
  // from how many edges have elapsed since then.
  int          cyc, t0, old_id, tgt, m_active, idle_run;
  bit          in_seq, fresh, m_done, m_err;
  logic [37:0] m_oeb;
  logic [37:0] tbl [8];

  task automatic model_reset();
    cyc = 0; t0 = -Q; old_id = 0; tgt = 0; m_active = 0; idle_run = 0;
    in_seq = 1; fresh = 1; m_done = 0; m_err = 0; m_oeb = ALL1;
    for (int i = 0; i < 8; i++) tbl[i] = ALL1;
  endtask

  task automatic model_step();
    int d; bit rot, fire;
    cyc++; fresh = 0; m_done = 0; m_err = 0;
    rot = rotate_en && rotate_period != 0;
    if (in_seq) begin
      d = cyc - t0;
      if (d == Q + 1) begin m_active = tgt; idle_run = 0; end
      if (d == Q + R + 1) begin in_seq = 0; m_oeb = tbl[tgt]; m_done = 1; end
    end else begin
      if (rot) idle_run++; else idle_run = 0;
      fire = rot && idle_run >= int'(rotate_period);
      if (fire) idle_run = 0;
      if (req_valid) begin
        if (req_project >= 8) m_err = 1;
        else begin in_seq = 1; t0 = cyc; old_id = m_active; tgt = req_project; end
      end else if (fire) begin
        in_seq = 1; t0 = cyc; old_id = m_active; tgt = (m_active + 1) % 8;
      end
    end
    if (cfg_we && cfg_project < 8) tbl[cfg_project] = cfg_oeb;
  endtask

  task automatic compare();
    logic [7:0] e_pr; int d; bit e_busy;
    d = cyc - t0;
    if (fresh)       e_pr = 8'hFF;
    else if (in_seq) e_pr = 8'(1) << ((d <= Q) ? old_id : tgt);
    else             e_pr = 8'h00;
    e_busy = fresh || in_seq;
    chk("m_active", active_project, 8'(m_active));
    chk("m_io_oeb", io_oeb, e_busy ? ALL1 : m_oeb);
    chk("m_proj_reset", proj_reset, e_pr);
    chk("m_busy", busy, e_busy);
    chk("m_ready", req_ready, !e_busy);
    chk("m_done", done, m_done);
    chk("m_err", err_invalid, m_err);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset(); else model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    compare();
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    do begin tick(); k++; end while (done !== 1'b1 && k < 60);
    chk(name, done, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 0; req_project = 0; cfg_we = 0; cfg_project = 0; cfg_oeb = '0;
    rotate_en = 0; rotate_period = 0;
    #1 rst = 1;
    repeat (3) @(negedge clk);
    #1 rst = 0;
    #1;
    // 1. reset release
    chk("rst_proj_reset", proj_reset, 8'hFF);
    chk("rst_io_oeb", io_oeb, ALL1);
    chk("rst_busy", busy, 1);
    chk("rst_ready", req_ready, 0);
    chk("rst_active", active_project, 0);
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (i < 9) chk("boot_p0_reset", proj_reset, 8'h01);
      else begin
        chk("boot_done", done, 1);
        chk("boot_ready", req_ready, 1);
        chk("boot_release", proj_reset, 8'h00);
      end
    end

    // 2. configure project 3 and switch to it
    tick();
    cfg_we = 1; cfg_project = 3; cfg_oeb = 38'h00_0000_FF00;
    tick();
    cfg_we = 0; req_valid = 1; req_project = 3;
    tick();
    req_valid = 0;
    chk("quiesce_oeb", io_oeb, ALL1);
    for (int d = 1; d <= 13; d++) begin
      tick();
      if (d == 12) begin cfg_we = 1; cfg_project = 3; cfg_oeb = 38'h3F_FFFF_0000; end
      if (d == 13) cfg_we = 0;
      if (d < 5) begin
        chk("q_active_old", active_project, 0);
        chk("q_reset_old", proj_reset, 8'h01);
      end else if (d < 13) begin
        chk("rel_active_new", active_project, 3);
        chk("rel_reset_new", proj_reset, 8'h08);
      end else begin
        chk("p3_oeb_old_value", io_oeb, 38'h00_0000_FF00);
        chk("p3_done", done, 1);
      end
    end

    // 3. invalid ids (full 8-bit compare)
    req_valid = 1; req_project = 9;
    tick();
    req_valid = 0;
    chk("inv_err", err_invalid, 1);
    chk("inv_active", active_project, 3);
    chk("inv_oeb", io_oeb, 38'h00_0000_FF00);
    chk("inv_ready", req_ready, 1);
    chk("inv_busy", busy, 0);
    tick();
    chk("inv_err_pulse", err_invalid, 0);
    req_valid = 1; req_project = 8'h83;
    tick();
    req_valid = 0;
    chk("inv_err_hi", err_invalid, 1);
    chk("inv_busy_hi", busy, 0);

    // 4. rotation
    rotate_en = 1; rotate_period = 20; req_valid = 1; req_project = 7;
    tick();
    req_valid = 0;
    wait_done("p7_done");
    chk("p7_active", active_project, 7);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 19) chk("rot_not_yet", busy, 0);
      if (k == 20) chk("rot_fire", busy, 1);
    end
    wait_done("rot0_done");
    chk("rot_wrap_to_0", active_project, 0);
    repeat (20) tick();
    chk("rot_fire2", busy, 1);
    wait_done("rot1_done");
    chk("rot_to_1", active_project, 1);
    repeat (19) tick();
    req_valid = 1; req_project = 5;
    tick();
    req_valid = 0;
    chk("collide_busy", busy, 1);
    wait_done("ext5_done");
    chk("ext_wins", active_project, 5);
    rotate_en = 0;

    // 5. async reset during RELEASE of project 2
    tick();
    req_valid = 1; req_project = 2;
    tick();
    req_valid = 0;
    repeat (8) tick();
    chk("p2_in_release", proj_reset, 8'h04);
    #1 rst = 1;
    #1;
    chk("arst_proj_reset", proj_reset, 8'hFF);
    chk("arst_active", active_project, 0);
    chk("arst_oeb", io_oeb, ALL1);
    chk("arst_busy", busy, 1);
    chk("arst_ready", req_ready, 0);
    tick(); tick();
    #1 rst = 0;
    wait_done("post_rst_done");
    chk("post_rst_active", active_project, 0);
    chk("post_rst_oeb", io_oeb, ALL1);
    repeat (5) tick();
    chk("no_replay", busy, 0);

    // 6. back-to-back with req_valid held
    cfg_we = 1; cfg_project = 4; cfg_oeb = 38'h15_5555_5555;
    tick();
    cfg_project = 6; cfg_oeb = 38'h2A_AAAA_AAAA;
    tick();
    cfg_we = 0; req_valid = 1; req_project = 4;
    tick();
    chk("b2b_first", busy, 1);
    req_project = 6;
    wait_done("b2b_done1");
    chk("b2b_ready", req_ready, 1);
    chk("b2b_active4", active_project, 4);
    chk("b2b_oeb4", io_oeb, 38'h15_5555_5555);
    tick();
    chk("b2b_second", busy, 1);
    req_valid = 0;
    wait_done("b2b_done2");
    chk("b2b_active6", active_project, 6);
    chk("b2b_oeb6", io_oeb, 38'h2A_AAAA_AAAA);
    cfg_we = 1; cfg_project = 6; cfg_oeb = '0;
    tick();
    cfg_project = 8'd200; cfg_oeb = 38'h00_0000_0F0F;
    tick();
    cfg_we = 0;
    chk("active_write_deferred", io_oeb, 38'h2A_AAAA_AAAA);
    req_valid = 1; req_project = 6;
    tick();
    req_valid = 0;
    wait_done("reselect_done");
    chk("reselect_oeb", io_oeb, 38'h0);
    req_valid = 1; req_project = 0;
    tick();
    req_valid = 0;
    wait_done("p0_done");
    chk("cfg_oob_ignored", io_oeb, ALL1);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
